psum_accumulator: RTL

Receiving end of the MAC array's partial-sum stream. The two input-channel groups of each output channel arrive as two full maps. Group-0 partial sums are parked in an internal map buffer. Each group-1 beat is summed with its parked partner and with the identity (residual) operand, then requantized, ReLU-clamped and emitted to the output-map writer over a valid/ready handshake.

---
 rtl/psum_accumulator.sv | 137 +++++++++++++
 1 files changed

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: parks group-0 maps, then adds each group-1 beat to its
// parked partner and the residual operand, requantizes, clamps and emits the result.
module psum_accumulator #(
  parameter int DATA_W   = 32,
  parameter int MAP_SIZE = 3136,
  parameter int ADDR_W   = 12,
  parameter int SHIFT    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_info,
  input  logic [7:0]        identity_in,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [7:0]        out_data,
  output logic [ADDR_W:0]   out_addr,
  output logic              frame_done,
  output logic              seq_err
);

  localparam int SW = DATA_W + 2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAP_SIZE - 1);

  logic              in_grp, in_half;
  logic [ADDR_W-1:0] in_off;
  logic              unused_info;

  assign in_off      = in_info[ADDR_W-1:0];
  assign in_grp      = in_info[12];
  assign in_half     = in_info[13];
  assign unused_info = ^in_info[31:14];

  logic                     s1_vld_q;
  logic signed [DATA_W-1:0] s1_data_q;
  logic signed [7:0]        s1_id_q;
  logic                     s1_half_q;
  logic [ADDR_W-1:0]        s1_off_q;
  logic signed [DATA_W-1:0] buf_rd_q;
  logic [DATA_W-1:0]        buf_mem [MAP_SIZE];

  logic              out_vld_q;
  logic [7:0]        out_data_q, out_data_d;
  logic [ADDR_W:0]   out_addr_q;
  logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
  logic              exp_grp_q;
  logic [ADDR_W-1:0] exp_off_q, exp_off_d;
  logic              seq_err_q;

  logic s1_adv, acc, acc_g0, acc_g1, out_hs;
  logic signed [SW-1:0] sum_w, q_w;

  assign s1_adv = !out_vld_q || out_rdy;
  assign in_rdy = !s1_vld_q || s1_adv;
  assign acc    = in_vld && in_rdy;
  assign acc_g0 = acc && !in_grp;
  assign acc_g1 = acc && in_grp;
  assign out_hs = out_vld_q && out_rdy;

  // Widened by two bits so the three-operand sum can never wrap.
  assign sum_w = SW'(buf_rd_q) + SW'(s1_data_q) + (SW'(s1_id_q) <<< SHIFT);
  assign q_w   = sum_w >>> SHIFT;

  always_comb begin
    out_data_d = q_w[7:0];
    if (q_w < 0)
      out_data_d = 8'd0;
    else if (q_w > 255)
      out_data_d = 8'd255;
  end

  assign out_cnt_d = (out_cnt_q == LAST) ? '0 : out_cnt_q + 1'b1;
  assign exp_off_d = (exp_off_q == LAST) ? '0 : exp_off_q + 1'b1;

  // Read enable only on accept, so buf_rd_q holds its value while S1 stalls.
  always_ff @(posedge clk) begin
    if (acc_g0)
      buf_mem[in_off] <= in_data;
    if (acc_g1)
      buf_rd_q <= buf_mem[in_off];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
      s1_half_q  <= 1'b0;
      s1_off_q   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_addr_q <= '0;
      out_cnt_q  <= '0;
      exp_grp_q  <= 1'b0;
      exp_off_q  <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      if (acc_g1) begin
        s1_vld_q  <= 1'b1;
        s1_data_q <= in_data;
        s1_id_q   <= identity_in;
        s1_half_q <= in_half;
        s1_off_q  <= in_off;
      end else if (s1_adv) begin
        s1_vld_q <= 1'b0;
      end

      if (s1_vld_q && s1_adv) begin
        out_vld_q  <= 1'b1;
        out_data_q <= out_data_d;
        out_addr_q <= {s1_half_q, s1_off_q};
      end else if (out_rdy) begin
        out_vld_q <= 1'b0;
      end

      if (out_hs)
        out_cnt_q <= out_cnt_d;

      if (acc) begin
        exp_off_q <= exp_off_d;
        if (exp_off_q == LAST)
          exp_grp_q <= !exp_grp_q;
        if (in_grp != exp_grp_q || in_off != exp_off_q)
          seq_err_q <= 1'b1;
      end
    end
  end

  assign out_vld    = out_vld_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign frame_done = out_hs && (out_cnt_q == LAST);
  assign seq_err    = seq_err_q;

endmodule
